// File: rtl/match_sequencer_pkg.sv
// match_sequencer shared definitions: FSM state encoding and
// reset-default values for the configuration registers.
package match_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MATCH_A_RST = 5;
    localparam int MATCH_B_RST = 3;
    localparam int LIMIT_RST   = 15;

endpackage

// File: rtl/match_sequencer_tick.sv
// tick_gen: prescaler counting 0..TICK_DIV-1 while enabled.
// Ports: clk, rst (sync, high), clr (sync clear), en, tick (1-cycle).
module tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;

    assign tick = en && !clr && (pre == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre <= '0;
        end else if (en) begin
            if (tick) begin
                pre <= '0;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: steps a counter 0..limit at a prescaled rate
// and flags when count equals either match value.
// Ports: clk, rst (sync, high); start/stop run control;
// cfg_we + cfg_* config load (IDLE only);
// busy, count, result, done registered status outputs.
module match_sequencer
    import match_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_match_a,
    input  logic [CW-1:0] cfg_match_b,
    input  logic [CW-1:0] cfg_limit,
    input  logic          cfg_continuous,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic          result,
    output logic          done
);

    state_t        state, state_n;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] ma, mb, lim;
    logic [CW-1:0] ma_n, mb_n, lim_n;
    logic          cont, cont_n;
    logic          tick;
    logic          pclr;
    logic          pen;

    // Prescaler only runs in RUN; a stop also restarts it.
    assign pen  = (state == RUN);
    assign pclr = (state != RUN) || stop;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (pclr),
        .en  (pen),
        .tick(tick)
    );

    always_comb begin
        state_n = state;
        cnt_n   = count;
        ma_n    = ma;
        mb_n    = mb;
        lim_n   = lim;
        cont_n  = cont;

        // Config visible immediately so a start in the
        // same cycle runs with the freshly loaded values.
        if (state == IDLE && cfg_we) begin
            ma_n   = cfg_match_a;
            mb_n   = cfg_match_b;
            lim_n  = cfg_limit;
            cont_n = cfg_continuous;
        end

        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (tick) begin
                    if (count == lim) begin
                        if (cont) begin
                            cnt_n = '0;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        cnt_n = count + CW'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            busy   <= 1'b0;
            result <= 1'b0;
            done   <= 1'b0;
            ma     <= CW'(MATCH_A_RST);
            mb     <= CW'(MATCH_B_RST);
            lim    <= CW'(LIMIT_RST);
            cont   <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= cnt_n;
            ma     <= ma_n;
            mb     <= mb_n;
            lim    <= lim_n;
            cont   <= cont_n;
            busy   <= (state_n != IDLE);
            done   <= (state_n == DONE);
            // Registered from next-count so it lines up with count.
            result <= (state_n == RUN)
                   && ((cnt_n == ma_n) || (cnt_n == mb_n));
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed vectors for match_sequencer with
// TICK_DIV=1 (u1) and TICK_DIV=3 (u3) instances on shared inputs.
module tb_match_sequencer;

    typedef struct {
        logic       start;
        logic       stop;
        logic       we;
        logic [3:0] ma;
        logic [3:0] mb;
        logic [3:0] lim;
        logic       cont;
        logic       busy;
        logic [3:0] cnt;
        logic       res;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start, stop, cfg_we, cont;
    logic [3:0] ma, mb, lim;
    logic       busy1, res1, done1;
    logic [3:0] cnt1;
    logic       busy3, res3, done3;
    logic [3:0] cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    match_sequencer #(.TICK_DIV(1), .CW(4)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_we(cfg_we), .cfg_match_a(ma), .cfg_match_b(mb),
        .cfg_limit(lim), .cfg_continuous(cont),
        .busy(busy1), .count(cnt1), .result(res1), .done(done1)
    );

    match_sequencer #(.TICK_DIV(3), .CW(4)) u3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_we(cfg_we), .cfg_match_a(ma), .cfg_match_b(mb),
        .cfg_limit(lim), .cfg_continuous(cont),
        .busy(busy3), .count(cnt3), .result(res3), .done(done3)
    );

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        step();
        rst = 1'b0;
    endtask

    task automatic apply(string tag, vec_t v);
        start  = v.start;
        stop   = v.stop;
        cfg_we = v.we;
        ma     = v.ma;
        mb     = v.mb;
        lim    = v.lim;
        cont   = v.cont;
        step();
        chk({tag, "_busy"}, busy1, v.busy);
        chk({tag, "_cnt"}, cnt1, v.cnt);
        chk({tag, "_res"}, res1, v.res);
        chk({tag, "_done"}, done1, v.done);
    endtask

    // Default config run on u1; caller has just applied start.
    task automatic run16(string tag);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_cnt"}, cnt1, i);
            chk({tag, "_res"}, res1, (i == 3 || i == 5));
            chk({tag, "_busy"}, busy1, 1);
            step();
        end
        chk({tag, "_done"}, done1, 1);
        chk({tag, "_dcnt"}, cnt1, 15);
        step();
        chk({tag, "_idle"}, busy1, 0);
    endtask

    vec_t t1[18];
    vec_t t3[14];

    initial begin
        int  seen;
        // Test 1 table: defaults, TICK_DIV=1
        t1[0] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 1; i < 16; i++) begin
            t1[i] = '{0, 0, 0, 0, 0, 0, 0,
                      1, 4'(i), (i == 3 || i == 5), 0};
        end
        t1[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 15, 0, 1};
        t1[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 0};
        // Test 3 table: continuous, limit 4, match 0/4
        t3[0]  = '{1, 0, 1, 0, 4, 4, 1, 1, 0, 1, 0};
        t3[1]  = '{0, 0, 0, 0, 4, 4, 1, 1, 1, 0, 0};
        t3[2]  = '{0, 0, 0, 0, 4, 4, 1, 1, 2, 0, 0};
        t3[3]  = '{0, 0, 0, 0, 4, 4, 1, 1, 3, 0, 0};
        t3[4]  = '{0, 0, 0, 0, 4, 4, 1, 1, 4, 1, 0};
        t3[5]  = '{0, 0, 0, 0, 4, 4, 1, 1, 0, 1, 0};
        t3[6]  = '{0, 0, 0, 0, 4, 4, 1, 1, 1, 0, 0};
        t3[7]  = '{0, 0, 0, 0, 4, 4, 1, 1, 2, 0, 0};
        t3[8]  = '{0, 0, 0, 0, 4, 4, 1, 1, 3, 0, 0};
        t3[9]  = '{0, 0, 0, 0, 4, 4, 1, 1, 4, 1, 0};
        t3[10] = '{0, 0, 0, 0, 4, 4, 1, 1, 0, 1, 0};
        t3[11] = '{0, 0, 0, 0, 4, 4, 1, 1, 1, 0, 0};
        t3[12] = '{0, 1, 0, 0, 4, 4, 1, 0, 0, 0, 0};
        t3[13] = '{0, 0, 0, 0, 4, 4, 1, 0, 0, 0, 0};

        ma   = 4'd0;
        mb   = 4'd0;
        lim  = 4'd0;
        cont = 1'b0;
        do_reset();
        chk("rst_busy", busy1, 0);
        chk("rst_cnt", cnt1, 0);
        chk("rst_res", res1, 0);
        chk("rst_done", done1, 0);
        chk("rst_busy3", busy3, 0);

        // 1: defaults, one-shot 0..15
        for (int i = 0; i < 18; i++) apply($sformatf("t1_%0d", i), t1[i]);

        // 3: continuous wrap, then stop
        for (int i = 0; i < 14; i++) apply($sformatf("t3_%0d", i), t3[i]);

        // 2: TICK_DIV=3 on u3
        do_reset();
        ma = 4'd2; mb = 4'd9; lim = 4'd9; cont = 1'b0;
        cfg_we = 1'b1;
        start  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 3; k++) begin
                step();
                idle_in();
                chk("t2_cnt", cnt3, c);
                chk("t2_res", res3, (c == 2 || c == 9));
                chk("t2_busy", busy3, 1);
                chk("t2_done", done3, 0);
            end
        end
        step();
        chk("t2_done_pulse", done3, 1);
        chk("t2_done_cnt", cnt3, 9);
        chk("t2_done_busy", busy3, 1);
        step();
        chk("t2_idle_busy", busy3, 0);
        chk("t2_idle_done", done3, 0);
        chk("t2_idle_cnt", cnt3, 9);

        // 4: stop coincident with limit tick (u1)
        do_reset();
        lim = 4'd2; cont = 1'b0;
        cfg_we = 1'b1;
        start  = 1'b1;
        step();
        idle_in();
        chk("t4_c0", cnt1, 0);
        step();
        chk("t4_c1", cnt1, 1);
        step();
        chk("t4_c2", cnt1, 2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_busy", busy1, 0);
        chk("t4_cnt", cnt1, 0);
        chk("t4_res", res1, 0);
        chk("t4_done", done1, 0);
        step();
        chk("t4_done2", done1, 0);

        // 5: cfg_we and start ignored while busy
        do_reset();
        ma = 4'd5; mb = 4'd3; lim = 4'd15; cont = 1'b0;
        start = 1'b1;
        step();
        idle_in();
        step();
        chk("t5_c1", cnt1, 1);
        ma = 4'd7; mb = 4'd7; lim = 4'd3; cont = 1'b1;
        cfg_we = 1'b1;
        start  = 1'b1;
        step();
        idle_in();
        chk("t5_c2", cnt1, 2);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            step();
            if (done1) seen = 1;
        end
        chk("t5_done_seen", seen, 1);
        chk("t5_done_cnt", cnt1, 15);
        step();
        chk("t5_idle", busy1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        run16("t5_rerun");

        // 6: reset mid-run restores config
        do_reset();
        ma = 4'd1; mb = 4'd2; lim = 4'd8; cont = 1'b1;
        cfg_we = 1'b1;
        start  = 1'b1;
        step();
        idle_in();
        for (int i = 0; i < 6; i++) step();
        chk("t6_c6", cnt1, 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_cnt", cnt1, 0);
        chk("t6_busy", busy1, 0);
        chk("t6_res", res1, 0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        idle_in();
        chk("t6_ss_busy", busy1, 0);
        chk("t6_ss_cnt", cnt1, 0);
        step();
        chk("t6_ss_busy2", busy1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        run16("t6_run");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
